ud_bcd_counter_n: RTL and testbench



---
 rtl/ud_bcd_counter_n.sv | 98 +++++++++
 tb/tb_ud_bcd_counter_n.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/ud_bcd_counter_n.sv
// rtl/ud_bcd_counter_n.sv - multi-digit up/down packed-BCD counter with load, cascade tc and sticky wrap
// Optional BCD_SAT_EN: saturate at all 9s / all 0s instead of wrapping.
module ud_bcd_counter_n #(
   parameter int DIGITS = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic                  x,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   din,
   output logic [4*DIGITS-1:0]   q,
   output logic                  tc,
   output logic                  wrap,
   output logic                  err
);

   localparam int W = 4*DIGITS;

   logic [W-1:0] q_up;
   logic [W-1:0] q_dn;
   logic [W-1:0] din_fix;
   logic         din_bad;
   logic         all_nine;
   logic         all_zero;
   logic         carry;
   logic         borrow;
   logic [3:0]   dig;
   logic [3:0]   ld_dig;

   // Ripple carry/borrow across all digits in one cycle; q is always valid BCD.
   always_comb begin
      q_up     = q;
      q_dn     = q;
      din_fix  = din;
      din_bad  = 1'b0;
      all_nine = 1'b1;
      all_zero = 1'b1;
      carry    = 1'b1;
      borrow   = 1'b1;
      dig      = 4'd0;
      ld_dig   = 4'd0;
      for (int i = 0; i < DIGITS; i++) begin
         dig = q[4*i +: 4];
         if (carry)
            q_up[4*i +: 4] = (dig == 4'd9) ? 4'd0 : dig + 4'd1;
         if (borrow)
            q_dn[4*i +: 4] = (dig == 4'd0) ? 4'd9 : dig - 4'd1;
         carry    = carry  & (dig == 4'd9);
         borrow   = borrow & (dig == 4'd0);
         all_nine = all_nine & (dig == 4'd9);
         all_zero = all_zero & (dig == 4'd0);
         ld_dig = din[4*i +: 4];
         if (ld_dig > 4'd9) begin
            din_fix[4*i +: 4] = 4'd0;
            din_bad           = 1'b1;
         end
      end
   end

   assign tc = en & ((~x & all_nine) | (x & all_zero));

   always_ff @(posedge clk) begin
      if (!rst) begin
         q    <= '0;
         wrap <= 1'b0;
         err  <= 1'b0;
      end else if (load) begin
         q    <= din_fix;
         err  <= din_bad;
         wrap <= 1'b0;
      end else begin
         err <= 1'b0;
         if (en) begin
            if (!x) begin
               if (all_nine)
                  wrap <= 1'b1;
`ifdef BCD_SAT_EN
               if (!all_nine)
                  q <= q_up;
`else
               q <= q_up;
`endif
            end else begin
               if (all_zero)
                  wrap <= 1'b1;
`ifdef BCD_SAT_EN
               if (!all_zero)
                  q <= q_dn;
`else
               q <= q_dn;
`endif
            end
         end
      end
   end

endmodule

// File: tb/tb_ud_bcd_counter_n.sv
// tb/tb_ud_bcd_counter_n.sv - self-checking bench for ud_bcd_counter_n against an integer reference model
module tb_ud_bcd_counter_n;

   localparam int MAXV = 9999;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic        x;
   logic        load;
   logic [15:0] din;
   logic [15:0] q;
   logic        tc;
   logic        wrap;
   logic        err;
   logic [7:0]  lo_q;
   logic [7:0]  hi_q;
   logic        lo_tc;
   logic        hi_tc;
   logic        lo_wrap;
   logic        hi_wrap;
   logic        lo_err;
   logic        hi_err;

   int n_cmp = 0;
   int n_bad = 0;
   int val   = 0;
   logic wrap_m = 1'b0;
   logic err_m  = 1'b0;
   logic known  = 1'b0;

   always #5 clk = ~clk;

   ud_bcd_counter_n #(.DIGITS(4)) dut (
      .clk(clk), .rst(rst), .en(en), .x(x), .load(load), .din(din),
      .q(q), .tc(tc), .wrap(wrap), .err(err)
   );

   ud_bcd_counter_n #(.DIGITS(2)) u_lo (
      .clk(clk), .rst(rst), .en(en), .x(x), .load(load), .din(din[7:0]),
      .q(lo_q), .tc(lo_tc), .wrap(lo_wrap), .err(lo_err)
   );

   ud_bcd_counter_n #(.DIGITS(2)) u_hi (
      .clk(clk), .rst(rst), .en(lo_tc), .x(x), .load(load), .din(din[15:8]),
      .q(hi_q), .tc(hi_tc), .wrap(hi_wrap), .err(hi_err)
   );

   function automatic logic [15:0] to_bcd(input int v);
      logic [15:0] r;
      int t;
      t = v;
      for (int i = 0; i < 4; i++) begin
         r[4*i +: 4] = 4'(t % 10);
         t = t / 10;
      end
      return r;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Apply one cycle of inputs, check tc before the edge and state after it.
   task automatic step(input logic r, input logic ld, input logic e, input logic dir,
                       input logic [15:0] d);
      int nv;
      logic bad;
      logic exp_tc;
      rst = r; load = ld; en = e; x = dir; din = d;
      #1;
      if (known) begin
         exp_tc = e && ((!dir && val == MAXV) || (dir && val == 0));
         chk("tc", {31'd0, tc}, {31'd0, exp_tc});
      end
      @(posedge clk);
      if (!r) begin
         val = 0; wrap_m = 1'b0; err_m = 1'b0; known = 1'b1;
      end else if (ld) begin
         nv = 0; bad = 1'b0;
         for (int i = 3; i >= 0; i--) begin
            if (int'(d[4*i +: 4]) > 9) begin
               bad = 1'b1;
               nv = nv * 10;
            end else begin
               nv = nv * 10 + int'(d[4*i +: 4]);
            end
         end
         val = nv; err_m = bad; wrap_m = 1'b0;
      end else begin
         err_m = 1'b0;
         if (e && !dir) begin
            if (val == MAXV) begin
               wrap_m = 1'b1;
`ifdef BCD_SAT_EN
               val = MAXV;
`else
               val = 0;
`endif
            end else val = val + 1;
         end else if (e && dir) begin
            if (val == 0) begin
               wrap_m = 1'b1;
`ifdef BCD_SAT_EN
               val = 0;
`else
               val = MAXV;
`endif
            end else val = val - 1;
         end
      end
      @(negedge clk);
      chk("q", {16'd0, q}, {16'd0, to_bcd(val)});
      chk("wrap", {31'd0, wrap}, {31'd0, wrap_m});
      chk("err", {31'd0, err}, {31'd0, err_m});
`ifndef BCD_SAT_EN
      chk("cascade_q", {16'd0, hi_q, lo_q}, {16'd0, to_bcd(val)});
`endif
   endtask

   initial begin
      logic [15:0] rd;
      rst = 1'b0; load = 1'b0; en = 1'b0; x = 1'b0; din = '0;
      @(negedge clk);

      step(0, 0, 0, 0, 16'h0000);
      chk("plan_reset_q", {16'd0, q}, 32'h0000);
      for (int i = 0; i < 12; i++) step(1, 0, 1, 0, 16'h0000);
      chk("plan_up12", {16'd0, q}, 32'h0012);

      step(1, 1, 0, 0, 16'h0999);
      step(1, 0, 1, 0, 16'h0000);
      chk("plan_carry", {16'd0, q}, 32'h1000);
      step(1, 1, 0, 0, 16'h1000);
      step(1, 0, 1, 1, 16'h0000);
      chk("plan_borrow", {16'd0, q}, 32'h0999);

      step(1, 1, 0, 0, 16'h9998);
      for (int i = 0; i < 3; i++) step(1, 0, 1, 0, 16'h0000);
`ifdef BCD_SAT_EN
      chk("plan_wrap_up", {16'd0, q}, 32'h9999);
`else
      chk("plan_wrap_up", {16'd0, q}, 32'h0001);
`endif
      chk("plan_wrap_flag", {31'd0, wrap}, 32'd1);

      step(1, 1, 0, 0, 16'h0001);
      step(1, 0, 1, 1, 16'h0000);
      step(1, 0, 1, 1, 16'h0000);
`ifdef BCD_SAT_EN
      chk("plan_wrap_dn", {16'd0, q}, 32'h0000);
`else
      chk("plan_wrap_dn", {16'd0, q}, 32'h9999);
`endif

      step(1, 1, 0, 0, 16'h0005);
      step(1, 0, 1, 0, 16'h0000);
      chk("plan_toggle_up", {16'd0, q}, 32'h0006);
      step(1, 0, 1, 1, 16'h0000);
      chk("plan_toggle_dn", {16'd0, q}, 32'h0005);

      step(1, 1, 0, 0, 16'h12A4);
      chk("plan_badload_q", {16'd0, q}, 32'h1204);
      chk("plan_badload_err", {31'd0, err}, 32'd1);
      step(1, 0, 0, 0, 16'h0000);
      chk("plan_err_clear", {31'd0, err}, 32'd0);

      step(1, 1, 1, 0, 16'h0345);
      chk("plan_load_en", {16'd0, q}, 32'h0345);

      step(1, 1, 0, 0, 16'h0457);
      step(0, 1, 1, 0, 16'h0888);
      chk("plan_rst_prio", {16'd0, q}, 32'h0000);

      for (int i = 0; i < 3000; i++) begin
         rd = 16'($urandom);
         if ($urandom_range(0, 3) != 0)
            for (int k = 0; k < 4; k++)
               if (rd[4*k +: 4] > 4'd9) rd[4*k +: 4] = 4'($urandom_range(0, 9));
         if ($urandom_range(0, 9) < 8)
            rd = (rd[0]) ? 16'h9999 - 16'($urandom_range(0, 2)) : 16'($urandom_range(0, 2));
         step(($urandom_range(0, 99) != 0), ($urandom_range(0, 19) == 0),
              ($urandom_range(0, 3) != 0), 1'($urandom), rd);
      end

      step(0, 0, 0, 0, 16'h0000);
      for (int i = 0; i < 10001; i++) step(1, 0, 1, 0, 16'h0000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
